imem_uart_loader: RTL and testbench

Serial program loader for the pipelined CPU system: receives an 8N1 UART byte stream from the host, frames it into 32-bit little-endian words and writes them sequentially into instruction memory. It is the write-side counterpart of the CPU's instruction fetch port. It holds the CPU clock gate (`cpu_hold`) while a load is in progress, so a program can be replaced without reprogramming the FPGA.

---
 rtl/loader_pkg.sv | 23 ++
 rtl/uart_rx_byte.sv | 101 ++++++++++
 rtl/imem_uart_loader.sv | 165 ++++++++++++++++
 tb/tb_imem_uart_loader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the UART instruction-memory loader.
package loader_pkg;

   // Byte that opens every program frame.
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   // Frame-level loader states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LEN  = 2'd1,
      DATA = 2'd2,
      CSUM = 2'd3
   } load_state_e;

   // Bit-level UART receiver states.
   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling,
// glitch rejection on the start bit, one-cycle valid/error pulses.
module uart_rx_byte
   import loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

   rx_state_e   state_q, state_d;
   logic [2:0]  sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
   logic        rx_s, rx_fall;

   // sync_q[1] is the synchronized line; sync_q[2] is its previous value.
   assign rx_s    = sync_q[1];
   assign rx_fall = sync_q[2] & ~sync_q[1];

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= RX_IDLE;
      else       state_q <= state_d;
   end

   // Next-state: start edge, half-bit glitch check, 8 data bits, stop bit.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RX_IDLE:  if (rx_fall) state_d = RX_START;
         RX_START: if (cnt_q == HALF) state_d = rx_s ? RX_IDLE : RX_DATA;
         RX_DATA:  if (cnt_q == FULL && bit_q == 3'd7) state_d = RX_STOP;
         RX_STOP:  if (cnt_q == FULL) state_d = RX_IDLE;
         default:  state_d = RX_IDLE;
      endcase
   end

   // Datapath next-state: bit timer, shift register and result pulses.
   always_comb begin
      cnt_d   = cnt_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      unique case (state_q)
         RX_IDLE:  cnt_d = '0;
         RX_START: if (cnt_q == HALF) begin
            cnt_d = '0;
            bit_d = '0;
         end
         RX_DATA:  if (cnt_q == FULL) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
         end
         RX_STOP:  if (cnt_q == FULL) begin
            cnt_d   = '0;
            valid_d = rx_s;
            ferr_d  = ~rx_s;
         end
         default:  cnt_d = '0;
      endcase
   end

   // Synchronizer and datapath registers; line idles high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q  <= 3'b111;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[1:0], rx};
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign data       = shift_q;
   assign byte_valid = valid_q;
   assign frame_err  = ferr_q;

endmodule

// File: rtl/imem_uart_loader.sv
// Frames a UART byte stream into little-endian 32-bit words and writes
// them sequentially into instruction memory, holding the CPU meanwhile.
module imem_uart_loader
   import loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_W       = 7
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              uart_rx,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_hold,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int LW = ADDR_W + 1;

   logic [7:0] rx_data;
   logic       rx_valid, rx_ferr;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .reset      (reset),
      .rx         (uart_rx),
      .data       (rx_data),
      .byte_valid (rx_valid),
      .frame_err  (rx_ferr)
   );

   load_state_e       state_q, state_d;
   logic [LW-1:0]     len_q, len_d;
   logic [LW-1:0]     words_q, words_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        idx_q, idx_d;
   logic [23:0]       word_q, word_d;     // first three bytes of the word
   logic [7:0]        csum_q, csum_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              last_word;

   assign last_word = (words_q + LW'(1)) == len_q;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state: a framing error anywhere inside a frame aborts to IDLE.
   always_comb begin
      state_d = state_q;
      if (state_q != IDLE && rx_ferr) begin
         state_d = IDLE;
      end else if (rx_valid) begin
         unique case (state_q)
            IDLE:    if (rx_data == SYNC_BYTE) state_d = LEN;
            LEN:     state_d = DATA;
            DATA:    if (idx_q == 2'd3 && last_word) state_d = CSUM;
            CSUM:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Datapath next-state: word assembly, address/count, checksum, flags.
   always_comb begin
      len_d   = len_q;
      words_d = words_q;
      addr_d  = addr_q;
      idx_d   = idx_q;
      word_d  = word_q;
      csum_d  = csum_q;
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      hold_d  = hold_q;
      done_d  = 1'b0;
      err_d   = err_q;
      if (state_q != IDLE && rx_ferr) begin
         hold_d = 1'b0;
         err_d  = 1'b1;
      end else if (rx_valid) begin
         unique case (state_q)
            IDLE: if (rx_data == SYNC_BYTE) begin
               hold_d  = 1'b1;
               err_d   = 1'b0;
               words_d = '0;
               addr_d  = '0;
               idx_d   = '0;
               csum_d  = '0;
            end
            // A zero length byte means a full memory image.
            LEN: len_d = (rx_data == 8'd0) ? (LW'(1) << ADDR_W) : LW'(rx_data);
            DATA: begin
               csum_d = csum_q ^ rx_data;
               word_d = {rx_data, word_q[23:8]};
               idx_d  = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  we_d    = 1'b1;
                  waddr_d = addr_q;
                  wdata_d = {rx_data, word_q};
                  addr_d  = addr_q + ADDR_W'(1);
                  words_d = words_q + LW'(1);
                  idx_d   = '0;
               end
            end
            CSUM: begin
               hold_d = 1'b0;
               if (rx_data == csum_q) done_d = 1'b1;
               else                   err_d  = 1'b1;
            end
            default: hold_d = 1'b0;
         endcase
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_q   <= '0;
         words_q <= '0;
         addr_q  <= '0;
         idx_q   <= '0;
         word_q  <= '0;
         csum_q  <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         hold_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         len_q   <= len_d;
         words_q <= words_d;
         addr_q  <= addr_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         csum_q  <= csum_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign im_we        = we_q;
   assign im_addr      = waddr_q;
   assign im_wdata     = wdata_q;
   assign cpu_hold     = hold_q;
   assign load_done    = done_q;
   assign load_err     = err_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader with CLKS_PER_BIT = 16.
module tb_imem_uart_loader;

   localparam int CPB    = 16;
   localparam int ADDR_W = 7;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              uart_rx = 1'b1;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic              cpu_hold;
   logic              load_done;
   logic              load_err;
   logic [ADDR_W:0]   words_loaded;

   int total = 0;
   int bad   = 0;

   imem_uart_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .reset        (rst),
      .uart_rx      (uart_rx),
      .im_we        (im_we),
      .im_addr      (im_addr),
      .im_wdata     (im_wdata),
      .cpu_hold     (cpu_hold),
      .load_done    (load_done),
      .load_err     (load_err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   // Monitor: log writes, pulses and pulse-to-byte_valid spacing.
   logic [ADDR_W-1:0] wr_addr[$];
   logic [31:0]       wr_data[$];
   int   done_cnt = 0, bv_cnt = 0, cyc = 0, last_bv = -100;
   int   rise_gap = -1, done_gap = -1;
   logic hold_prev = 1'b0, hold_before_done = 1'b0, hold_at_done = 1'b1;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (dut.rx_valid) begin
         bv_cnt  = bv_cnt + 1;
         last_bv = cyc;
      end
      if (im_we) begin
         wr_addr.push_back(im_addr);
         wr_data.push_back(im_wdata);
      end
      if (cpu_hold && !hold_prev) rise_gap = cyc - last_bv;
      if (load_done) begin
         done_cnt         = done_cnt + 1;
         done_gap         = cyc - last_bv;
         hold_before_done = hold_prev;
         hold_at_done     = cpu_hold;
      end
      hold_prev = cpu_hold;
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      uart_rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(posedge clk);
      end
      uart_rx = stop_bit;
      repeat (CPB) @(posedge clk);
      uart_rx = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (5) @(posedge clk);
      rst = 1'b0;
      repeat (1000) @(posedge clk);
      #1;
      total++; if (im_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", im_we); end
      total++; if (im_addr !== '0) begin bad++; $display("FAIL reset_addr got=%h want=0", im_addr); end
      total++; if (im_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h want=0", im_wdata); end
      total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL reset_hold got=%b want=0", cpu_hold); end
      total++; if (load_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", load_done); end
      total++; if (load_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", load_err); end
      total++; if (words_loaded !== '0) begin bad++; $display("FAIL reset_words got=%0d want=0", words_loaded); end
      total++; if (wr_addr.size() !== 0) begin bad++; $display("FAIL reset_no_write got=%0d want=0", wr_addr.size()); end
   endtask

   task automatic test_good_frame;
      int w0 = wr_addr.size();
      int d0 = done_cnt;
      logic [7:0] body[8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h05, 8'h40, 8'h00};
      send_byte(8'hA5, 1'b1);
      #1;
      total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL good_hold_up got=%b want=1", cpu_hold); end
      total++; if (rise_gap !== 1) begin bad++; $display("FAIL good_hold_rise_gap got=%0d want=1", rise_gap); end
      send_byte(8'h02, 1'b1);
      foreach (body[i]) send_byte(body[i], 1'b1);
      send_byte(8'hE5, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      total++; if (wr_addr.size() - w0 !== 2) begin bad++; $display("FAIL good_writes got=%0d want=2", wr_addr.size() - w0); end
      if (wr_addr.size() - w0 >= 2) begin
         total++; if (wr_addr[w0] !== 7'd0) begin bad++; $display("FAIL good_addr0 got=%h want=0", wr_addr[w0]); end
         total++; if (wr_data[w0] !== 32'h00000013) begin bad++; $display("FAIL good_data0 got=%h want=00000013", wr_data[w0]); end
         total++; if (wr_addr[w0+1] !== 7'd1) begin bad++; $display("FAIL good_addr1 got=%h want=1", wr_addr[w0+1]); end
         total++; if (wr_data[w0+1] !== 32'h004005B3) begin bad++; $display("FAIL good_data1 got=%h want=004005B3", wr_data[w0+1]); end
      end
      total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL good_done_count got=%0d want=1", done_cnt - d0); end
      total++; if (done_gap !== 1) begin bad++; $display("FAIL good_done_gap got=%0d want=1", done_gap); end
      total++; if (hold_before_done !== 1'b1 || hold_at_done !== 1'b0) begin bad++; $display("FAIL good_hold_fall got=%b%b want=10", hold_before_done, hold_at_done); end
      total++; if (words_loaded !== 8'd2) begin bad++; $display("FAIL good_words got=%0d want=2", words_loaded); end
      total++; if (load_err !== 1'b0) begin bad++; $display("FAIL good_err got=%b want=0", load_err); end
   endtask

   task automatic test_bad_csum;
      int w0 = wr_addr.size();
      int d0 = done_cnt;
      logic [7:0] body[8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h05, 8'h40, 8'h00};
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      foreach (body[i]) send_byte(body[i], 1'b1);
      send_byte(8'h00, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      total++; if (wr_addr.size() - w0 !== 2) begin bad++; $display("FAIL csum_writes got=%0d want=2", wr_addr.size() - w0); end
      total++; if (load_err !== 1'b1) begin bad++; $display("FAIL csum_err got=%b want=1", load_err); end
      total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL csum_no_done got=%0d want=0", done_cnt - d0); end
      total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL csum_hold got=%b want=0", cpu_hold); end
      send_byte(8'hA5, 1'b1);
      #1;
      total++; if (load_err !== 1'b0) begin bad++; $display("FAIL csum_sync_clears_err got=%b want=0", load_err); end
      total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL csum_resync_hold got=%b want=1", cpu_hold); end
      // Abort the open frame with a bad stop bit in LEN.
      send_byte(8'h01, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      total++; if (load_err !== 1'b1 || cpu_hold !== 1'b0) begin bad++; $display("FAIL csum_len_abort got=%b%b want=10", load_err, cpu_hold); end
   endtask

   task automatic test_garbage;
      int w0 = wr_addr.size();
      int d0 = done_cnt;
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_byte(8'h5A, 1'b1);
      #1;
      total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL garbage_no_hold got=%b want=0", cpu_hold); end
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h78, 1'b1);
      send_byte(8'h56, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h12, 1'b1);
      send_byte(8'h08, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      total++; if (wr_addr.size() - w0 !== 1) begin bad++; $display("FAIL garbage_writes got=%0d want=1", wr_addr.size() - w0); end
      if (wr_addr.size() - w0 >= 1) begin
         total++; if (wr_addr[w0] !== 7'd0 || wr_data[w0] !== 32'h12345678) begin bad++; $display("FAIL garbage_word got=%h:%h want=00:12345678", wr_addr[w0], wr_data[w0]); end
      end
      total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL garbage_done got=%0d want=1", done_cnt - d0); end
      total++; if (words_loaded !== 8'd1 || load_err !== 1'b0) begin bad++; $display("FAIL garbage_status got=%0d/%b want=1/0", words_loaded, load_err); end
   endtask

   task automatic test_frame_err;
      int w0 = wr_addr.size();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      send_byte(8'h33, 1'b1);
      send_byte(8'h44, 1'b1);
      send_byte(8'h55, 1'b1);
      send_byte(8'h66, 1'b1);
      send_byte(8'h77, 1'b0);
      repeat (20) @(posedge clk);
      #1;
      total++; if (wr_addr.size() - w0 !== 1) begin bad++; $display("FAIL ferr_writes got=%0d want=1", wr_addr.size() - w0); end
      if (wr_addr.size() - w0 >= 1) begin
         total++; if (wr_data[w0] !== 32'h44332211) begin bad++; $display("FAIL ferr_word0 got=%h want=44332211", wr_data[w0]); end
      end
      total++; if (load_err !== 1'b1) begin bad++; $display("FAIL ferr_err got=%b want=1", load_err); end
      total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL ferr_hold got=%b want=0", cpu_hold); end
      total++; if (words_loaded !== 8'd1) begin bad++; $display("FAIL ferr_words got=%0d want=1", words_loaded); end
      // Back in IDLE: a length-like byte must not start anything.
      send_byte(8'h02, 1'b1);
      #1;
      total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL ferr_idle got=%b want=0", cpu_hold); end
   endtask

   task automatic test_glitch;
      int b0 = bv_cnt;
      uart_rx = 1'b0;
      repeat (CPB / 4) @(posedge clk);
      uart_rx = 1'b1;
      repeat (300) @(posedge clk);
      #1;
      total++; if (bv_cnt - b0 !== 0) begin bad++; $display("FAIL glitch_byte_valid got=%0d want=0", bv_cnt - b0); end
   endtask

   task automatic test_reset_mid;
      int w0;
      int d0;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h13, 1'b1);
      send_byte(8'h00, 1'b1);
      #1;
      total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL rstmid_hold_before got=%b want=1", cpu_hold); end
      rst = 1'b1;
      #2;
      total++; if (cpu_hold !== 1'b0 || load_err !== 1'b0 || im_we !== 1'b0) begin bad++; $display("FAIL rstmid_async got=%b%b%b want=000", cpu_hold, load_err, im_we); end
      repeat (3) @(posedge clk);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      total++; if (words_loaded !== '0 || im_addr !== '0 || im_wdata !== 32'h0) begin bad++; $display("FAIL rstmid_values got=%0d/%h/%h want=0/0/0", words_loaded, im_addr, im_wdata); end
      w0 = wr_addr.size();
      d0 = done_cnt;
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'hEF, 1'b1);
      send_byte(8'hBE, 1'b1);
      send_byte(8'hAD, 1'b1);
      send_byte(8'hDE, 1'b1);
      send_byte(8'h22, 1'b1);
      repeat (20) @(posedge clk);
      #1;
      total++; if (wr_addr.size() - w0 !== 1) begin bad++; $display("FAIL rstmid_writes got=%0d want=1", wr_addr.size() - w0); end
      if (wr_addr.size() - w0 >= 1) begin
         total++; if (wr_addr[w0] !== 7'd0 || wr_data[w0] !== 32'hDEADBEEF) begin bad++; $display("FAIL rstmid_word got=%h:%h want=00:deadbeef", wr_addr[w0], wr_data[w0]); end
      end
      total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL rstmid_done got=%0d want=1", done_cnt - d0); end
   endtask

   initial begin
      test_reset;
      test_good_frame;
      test_bad_csum;
      test_garbage;
      test_frame_err;
      test_glitch;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
